// File: rtl/mcdp_pkg.sv
// mcdp_pkg: opcode/funct constants, ALU op and FSM state enums for the multi-cycle datapath.
package mcdp_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    return fn == FN_SUB ? ALU_SUB :
           fn == FN_AND ? ALU_AND :
           fn == FN_OR  ? ALU_OR  :
           fn == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic funct_known(input logic [5:0] fn);
    return fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT;
  endfunction
endpackage

// File: rtl/mcdp_regfile.sv
// mcdp_regfile: two async read ports, one sync write port, debug read port; register 0 reads as zero.
module mcdp_regfile
  import mcdp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [15:0]     dbg_out
);
  localparam int AW = NREGS > 1 ? $clog2(NREGS) : 1;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] dbg_full;
  // Indices wrap by keeping only the low AW bits; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa[AW-1:0] != '0) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end
  assign rd1      = regs[ra1[AW-1:0]];
  assign rd2      = regs[ra2[AW-1:0]];
  assign dbg_full = regs[dbg_sel[AW-1:0]];
  assign dbg_out  = dbg_full[15:0];
endmodule

// File: rtl/mcdp_core.sv
// mcdp_core: multi-cycle MIPS-subset datapath with control FSM and req/ack memory ports.
// Define MCDP_EARLY_BRANCH_EN to resolve beq in DECODE (2 cycles instead of 3).
module mcdp_core
  import mcdp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 8,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic [4:0]      dbg_sel,
  output logic [15:0]     dbg_out,
  output logic            halted
);
`ifdef MCDP_EARLY_BRANCH_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  state_e state, state_nx;
  logic run;
  logic [PC_W-1:0] pc, jt;
  logic [31:0] ir;
  logic [XLEN-1:0] a, b, aluout, mdr, rd1, rd2, imm_x, br_sum, alu_b, alu_y, wd;
  logic [5:0] op, fn;
  logic is_r, is_jr, known, is_mem;
  alu_op_e alu_op;
  assign op     = ir[31:26];
  assign fn     = ir[5:0];
  assign is_r   = op == OP_R;
  assign is_jr  = is_r && fn == FN_JR;
  assign is_mem = op == OP_LW || op == OP_SW;
  assign known  = (is_r && (funct_known(fn) || is_jr)) || op == OP_J || op == OP_BEQ ||
                  op == OP_ADDI || is_mem || op == OP_HALT;
  assign imm_x  = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign br_sum = XLEN'(pc) + (imm_x << 2);
  // Keep PC bits above the 28-bit jump field (if PC_W is that wide), replace the rest.
  assign jt     = (pc & ~PC_W'(28'hFFF_FFFF)) | PC_W'({ir[25:0], 2'b00});
  assign alu_op = is_r ? funct_to_alu(fn) : ALU_ADD;
  assign alu_b  = is_r ? b : imm_x;
  assign alu_y  = alu_op == ALU_SUB ? a - alu_b :
                  alu_op == ALU_AND ? a & alu_b :
                  alu_op == ALU_OR  ? a | alu_b :
                  alu_op == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(alu_b)} :
                  a + alu_b;
  assign wd     = op == OP_LW ? mdr : aluout;
  mcdp_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset),
    .ra1(ir[25:21]), .ra2(ir[20:16]),
    .we(state == S_WB), .wa(is_r ? ir[15:11] : ir[20:16]), .wd(wd),
    .dbg_sel(dbg_sel), .rd1(rd1), .rd2(rd2), .dbg_out(dbg_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = imem_req && imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_nx = op == OP_HALT ? S_HALT :
                           (!known || op == OP_J || is_jr || (EARLY && op == OP_BEQ)) ? S_FETCH : S_EXEC;
      S_EXEC:   state_nx = op == OP_BEQ ? S_FETCH : is_mem ? S_MEM : S_WB;
      S_MEM:    state_nx = !dmem_ack ? S_MEM : op == OP_LW ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      if (state == S_FETCH && imem_req && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_W'(4);
      end
      if (state == S_DECODE) begin
        a      <= rd1;
        b      <= rd2;
        aluout <= br_sum;
        if (op == OP_J) pc <= jt;
        if (is_jr) pc <= rd1[PC_W-1:0];
        if (EARLY && op == OP_BEQ && rd1 == rd2) pc <= br_sum[PC_W-1:0];
      end
      if (state == S_EXEC) begin
        if (op != OP_BEQ) aluout <= alu_y;
        else if (a == b) pc <= aluout[PC_W-1:0];
      end
      if (state == S_MEM && dmem_ack && op == OP_LW) mdr <= dmem_rdata;
    end
  end
  // The run flag holds off the first fetch request until the cycle after reset releases.
  assign imem_req   = run && state == S_FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = state == S_MEM;
  assign dmem_we    = dmem_req && op == OP_SW;
  assign dmem_addr  = aluout[PC_W-1:0];
  assign dmem_wdata = b;
  assign halted     = state == S_HALT;
endmodule

// File: tb/tb_mcdp_core.sv
// tb_mcdp_core: table-driven programs plus hand sequences for branches, jumps, waits and mid-access reset.
module tb_mcdp_core;
  import mcdp_pkg::*;
  localparam int XLEN = 32, PC_W = 8, NREGS = 32;
`ifdef MCDP_EARLY_BRANCH_EN
  localparam int BEQ_C = 2;
`else
  localparam int BEQ_C = 3;
`endif
  localparam logic [31:0] HLT = 32'hFC00_0000;
  logic clk, reset, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [PC_W-1:0] imem_addr, dmem_addr;
  logic [31:0] imem_rdata;
  logic [XLEN-1:0] dmem_wdata, dmem_rdata;
  logic [4:0] dbg_sel;
  logic [15:0] dbg_out;
  logic [31:0] imem [64];
  logic [XLEN-1:0] dmem [64];
  int iwait, dwait, icnt, dcnt;
  int checks, errors;
  int ncyc, nf, nd;
  logic [PC_W-1:0] fa [32];
  int fc [32];
  logic [PC_W-1:0] da [8];
  logic dwe [8];
  logic [XLEN-1:0] dwd [8];

  mcdp_core #(.XLEN(XLEN), .PC_W(PC_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_sel(dbg_sel), .dbg_out(dbg_out), .halted(halted)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign imem_rdata = imem[imem_addr[7:2]];
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign imem_ack   = imem_req && (icnt >= iwait);
  assign dmem_ack   = dmem_req && (dcnt >= dwait);
  always @(posedge clk) begin
    icnt <= (reset || !imem_req || imem_ack) ? 0 : icnt + 1;
    dcnt <= (reset || !dmem_req || dmem_ack) ? 0 : dcnt + 1;
    if (!reset && dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  function automatic logic [31:0] ri(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] o, input int rs, input int rt, input int imm);
    return {o, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jj(input int addr);
    return {OP_J, 26'(addr >> 2)};
  endfunction
  function automatic logic [5:0][31:0] p6(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_reg(input string nm, input int r, input logic [15:0] exp);
    dbg_sel = 5'(r);
    #1;
    chk(nm, {16'd0, dbg_out}, {16'd0, exp});
  endtask
  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic run_until_halt(input int max);
    bit started, done;
    started = 0;
    done = 0;
    ncyc = 0;
    nf = 0;
    nd = 0;
    for (int i = 0; i < 32; i++) begin
      fa[i] = '1;
      fc[i] = -1;
    end
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1;
      else begin
        if (imem_req) started = 1;
        if (started) ncyc++;
        if (imem_req && imem_ack && nf < 32) begin
          fa[nf] = imem_addr;
          fc[nf] = ncyc;
          nf++;
        end
        if (dmem_req && dmem_ack && nd < 8) begin
          da[nd] = dmem_addr;
          dwe[nd] = dmem_we;
          dwd[nd] = dmem_wdata;
          nd++;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout halted=%0b want 1", halted);
    end
  endtask

  typedef struct {
    logic [5:0][31:0] prog;
    int iw;
    int dw;
    int cyc;
    int ra;
    logic [15:0] va;
    int rb;
    logic [15:0] vb;
  } vec_t;
  vec_t tv [11];

  initial begin
    logic [PC_W-1:0] exp_fa [7];
    checks = 0;
    errors = 0;
    iwait = 0;
    dwait = 0;
    dbg_sel = 5'd3;
    clear_imem();
    tv[0]  = '{p6(ii(OP_ADDI,0,1,5), ii(OP_ADDI,0,2,-3), ri(1,2,3,FN_ADD), ri(2,1,4,FN_SLT), HLT, 0), 0, 0, 18, 3, 16'd2, 4, 16'd1};
    tv[1]  = '{p6(ii(OP_ADDI,0,1,12), ii(OP_ADDI,0,2,10), ri(1,2,3,FN_SUB), ri(1,2,4,FN_AND), HLT, 0), 0, 0, 18, 3, 16'd2, 4, 16'd8};
    tv[2]  = '{p6(ii(OP_ADDI,0,1,12), ii(OP_ADDI,0,2,10), ri(1,2,3,FN_OR), ri(1,2,4,FN_SLT), HLT, 0), 0, 0, 18, 3, 16'd14, 4, 16'd0};
    tv[3]  = '{p6(ii(OP_ADDI,0,1,5), ii(OP_SW,0,1,8), ii(OP_LW,0,5,8), HLT, 0, 0), 0, 1, 17, 5, 16'd5, 1, 16'd5};
    tv[4]  = '{p6(ii(OP_ADDI,0,0,7), ii(OP_ADDI,0,1,2), HLT, 0, 0, 0), 0, 0, 10, 0, 16'd0, 1, 16'd2};
    tv[5]  = '{p6(32'h4000_0000, ri(1,1,1,6'h3F), ii(OP_ADDI,0,1,1), HLT, 0, 0), 0, 0, 10, 1, 16'd1, 2, 16'd0};
    tv[6]  = '{p6(ii(OP_ADDI,0,1,-1), ii(OP_ADDI,0,2,1), ri(1,2,3,FN_ADD), HLT, 0, 0), 0, 0, 14, 3, 16'd0, 1, 16'hFFFF};
    tv[7]  = '{p6(ii(OP_ADDI,0,1,3), ii(OP_BEQ,1,1,1), ii(OP_ADDI,0,2,9), HLT, 0, 0), 0, 0, 6 + BEQ_C, 2, 16'd0, 1, 16'd3};
    tv[8]  = '{p6(ii(OP_ADDI,0,1,3), ii(OP_BEQ,1,0,1), ii(OP_ADDI,0,2,9), HLT, 0, 0), 0, 0, 10 + BEQ_C, 2, 16'd9, 1, 16'd3};
    tv[9]  = '{p6(ii(OP_ADDI,0,1,5), HLT, 0, 0, 0, 0), 1, 0, 8, 1, 16'd5, 0, 16'd0};
    tv[10] = '{p6(ii(OP_ADDI,0,1,3), ii(OP_ADDI,0,2,5), ri(1,2,3,FN_SUB), HLT, 0, 0), 0, 0, 14, 3, 16'hFFFE, 2, 16'd5};

    // Reset state and first fetch
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dbg", {16'd0, dbg_out}, 32'd0);
    reset = 0;
    #1;
    chk("rel_imem_req0", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("rel_imem_req1", {31'd0, imem_req}, 32'd1);
    chk("rel_imem_addr", {24'd0, imem_addr}, 32'd0);

    // Table of small programs
    for (int v = 0; v < 11; v++) begin
      clear_imem();
      for (int w = 0; w < 6; w++) imem[w] = tv[v].prog[w];
      iwait = tv[v].iw;
      dwait = tv[v].dw;
      do_reset();
      run_until_halt(400);
      chk($sformatf("v%0d_cycles", v), ncyc, tv[v].cyc);
      chk_reg($sformatf("v%0d_r%0d", v, tv[v].ra), tv[v].ra, tv[v].va);
      chk_reg($sformatf("v%0d_r%0d", v, tv[v].rb), tv[v].rb, tv[v].vb);
    end

    // Store then load with two data wait states
    clear_imem();
    imem[0] = ii(OP_ADDI,0,1,5);
    imem[1] = ii(OP_SW,0,1,8);
    imem[2] = ii(OP_LW,0,5,8);
    imem[3] = HLT;
    iwait = 0;
    dwait = 2;
    do_reset();
    run_until_halt(400);
    chk("ls_n", nd, 2);
    chk("ls_sw_addr", {24'd0, da[0]}, 32'd8);
    chk("ls_sw_we", {31'd0, dwe[0]}, 32'd1);
    chk("ls_sw_wdata", dwd[0], 32'd5);
    chk("ls_lw_addr", {24'd0, da[1]}, 32'd8);
    chk("ls_lw_we", {31'd0, dwe[1]}, 32'd0);
    chk("ls_lw_cycles", fc[3] - fc[2], 7);
    chk_reg("ls_r5", 5, 16'd5);

    // Taken and not-taken beq at 0x10
    for (int t = 0; t < 2; t++) begin
      clear_imem();
      imem[0] = ii(OP_ADDI,0,1,1);
      imem[1] = jj('h10);
      imem[4] = ii(OP_BEQ,1,t == 0 ? 1 : 0,2);
      imem[5] = HLT;
      imem[7] = HLT;
      dwait = 0;
      do_reset();
      run_until_halt(200);
      chk($sformatf("br%0d_fa2", t), {24'd0, fa[2]}, 32'h10);
      chk($sformatf("br%0d_fa3", t), {24'd0, fa[3]}, t == 0 ? 32'h1C : 32'h14);
      chk($sformatf("br%0d_j_cyc", t), fc[2] - fc[1], 2);
      chk($sformatf("br%0d_beq_cyc", t), fc[3] - fc[2], BEQ_C);
    end

    // j to 0x40, jr to 0x1FC truncated to 0xFC, then wrap to 0
    clear_imem();
    imem[0]  = ii(OP_BEQ,7,0,1);
    imem[1]  = HLT;
    imem[2]  = ii(OP_ADDI,0,6,'h1FC);
    imem[3]  = jj('h40);
    imem[16] = ri(6,0,0,FN_JR);
    imem[63] = ii(OP_ADDI,0,7,1);
    exp_fa = '{8'h00, 8'h08, 8'h0C, 8'h40, 8'hFC, 8'h00, 8'h04};
    do_reset();
    run_until_halt(300);
    chk("jw_nf", nf, 7);
    for (int k = 0; k < 7; k++) chk($sformatf("jw_fa%0d", k), {24'd0, fa[k]}, {24'd0, exp_fa[k]});
    chk("jw_j_cyc", fc[3] - fc[2], 2);
    chk("jw_jr_cyc", fc[4] - fc[3], 2);
    chk_reg("jw_r6", 6, 16'h01FC);
    chk_reg("jw_r7", 7, 16'd1);

    // Reset while a store is stalled in MEM
    clear_imem();
    imem[0] = ii(OP_ADDI,0,2,'h1234);
    imem[1] = ii(OP_SW,0,2,4);
    imem[2] = ii(OP_LW,0,1,4);
    imem[3] = HLT;
    dwait = 30;
    do_reset();
    for (int i = 0; i < 40 && !dmem_req; i++) @(negedge clk);
    chk("mr_stall_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mr_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("mr_imem_req", {31'd0, imem_req}, 32'd0);
    chk("mr_pc", {24'd0, imem_addr}, 32'd0);
    dwait = 0;
    @(negedge clk);
    reset = 0;
    run_until_halt(200);
    chk("mr_fa0", {24'd0, fa[0]}, 32'd0);
    chk("mr_cycles", ncyc, 15);
    chk_reg("mr_r1", 1, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
